// File: rtl/fp_pkg.sv
// fp_pkg: float format constants, classification helpers and accumulator state type
package fp_pkg;
   localparam int N_BIT = 32;
   localparam int MAN_BIT = 23;
   localparam int EXP_BIT = N_BIT - 1 - MAN_BIT;
   localparam logic [N_BIT-1:0] P_NAN = {1'b0, {EXP_BIT{1'b1}}, 1'b1, {(MAN_BIT-1){1'b0}}};
   localparam logic [N_BIT-1:0] INF = {1'b0, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
   typedef enum logic [0:0] {ACC, HOLD} accum_state_e;
   function automatic logic is_nan(input logic [N_BIT-1:0] x);
      return (&x[N_BIT-2:MAN_BIT]) && (|x[MAN_BIT-1:0]);
   endfunction
   function automatic logic is_inf(input logic [N_BIT-1:0] x);
      return x[N_BIT-2:0] == INF[N_BIT-2:0];
   endfunction
   function automatic logic is_zero(input logic [N_BIT-1:0] x);
      return x[N_BIT-2:0] == '0;
   endfunction
endpackage

// File: rtl/fp_accum_seq_fpaddsub.sv
// fpaddsub: combinational IEEE-style add/subtract, round-to-nearest-even, subnormals kept
module fpaddsub #(
   parameter int LOG_BIT = 5,
   parameter int EXP_BIT = 8
) (
   input  logic [(1<<LOG_BIT)-1:0] a,
   input  logic [(1<<LOG_BIT)-1:0] b,
   input  logic                    addnot_sub,
   output logic [(1<<LOG_BIT)-1:0] y
);
   localparam int N = 1 << LOG_BIT;
   localparam int M = N - 1 - EXP_BIT;
   localparam int W = M + 4;
   localparam logic [EXP_BIT-1:0] EMAX = '1;
   localparam logic [N-1:0] QNAN = {1'b0, EMAX, 1'b1, {(M-1){1'b0}}};
   logic sa, sb, sl, ss, swap, eff_sub, up, nan_a, nan_b, inf_a, inf_b;
   logic [EXP_BIT-1:0] ea, eb, el, es, d;
   logic [M:0] ma, mb, ml, msm;
   logic [2*W-1:0] wide;
   logic [W-1:0] lx, sx, n;
   logic [W:0] r;
   logic [EXP_BIT:0] lz, e, fe;
   logic [M+1:0] mr;
   always_comb begin
      sa = a[N-1];
      sb = b[N-1] ^ addnot_sub;
      // subnormals use exponent 1 with no hidden bit
      ea = (a[N-2:M] == '0) ? EXP_BIT'(1) : a[N-2:M];
      eb = (b[N-2:M] == '0) ? EXP_BIT'(1) : b[N-2:M];
      ma = {a[N-2:M] != '0, a[M-1:0]};
      mb = {b[N-2:M] != '0, b[M-1:0]};
      nan_a = (a[N-2:M] == EMAX) && (a[M-1:0] != '0);
      nan_b = (b[N-2:M] == EMAX) && (b[M-1:0] != '0);
      inf_a = (a[N-2:M] == EMAX) && (a[M-1:0] == '0);
      inf_b = (b[N-2:M] == EMAX) && (b[M-1:0] == '0);
      swap = b[N-2:0] > a[N-2:0];
      sl = swap ? sb : sa;
      ss = swap ? sa : sb;
      el = swap ? eb : ea;
      es = swap ? ea : eb;
      ml = swap ? mb : ma;
      msm = swap ? ma : mb;
      eff_sub = sl ^ ss;
      d = el - es;
      wide = {msm, 3'b0, {W{1'b0}}} >> ((d > EXP_BIT'(W)) ? EXP_BIT'(W) : d);
      sx = wide[2*W-1:W] | W'(|wide[W-1:0]);
      lx = {ml, 3'b0};
      r = eff_sub ? {1'b0, lx} - {1'b0, sx} : {1'b0, lx} + {1'b0, sx};
      lz = (EXP_BIT+1)'(W);
      for (int i = 0; i < W; i++) if (r[i]) lz = (EXP_BIT+1)'(W - 1 - i);
      n = r[W] ? {r[W:2], r[1] | r[0]} : (lz < {1'b0, el}) ? r[W-1:0] << lz : r[W-1:0] << (el - 1'b1);
      e = r[W] ? {1'b0, el} + 1'b1 : (lz < {1'b0, el}) ? {1'b0, el} - lz : '0;
      up = n[2] & (n[1] | n[0] | n[3]);
      mr = {1'b0, n[W-1:3]} + (M+2)'(up);
      fe = (e == '0) ? (EXP_BIT+1)'(mr[M]) : e + (EXP_BIT+1)'(mr[M+1]);
      y = (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) ? QNAN :
          inf_a ? {sa, EMAX, {M{1'b0}}} :
          inf_b ? {sb, EMAX, {M{1'b0}}} :
          (r == '0) ? {~eff_sub & sl, {(N-1){1'b0}}} :
          (fe >= {1'b0, EMAX}) ? {sl, EMAX, {M{1'b0}}} :
          {sl, fe[EXP_BIT-1:0], mr[M-1:0]};
   end
endmodule

// File: rtl/fp_accum_seq.sv
// fp_accum_seq: streams operands through fpaddsub into a running sum, presents one
// result per sequence with element count and sticky NaN/overflow flags
module fp_accum_seq import fp_pkg::*; #(
   parameter int LOG_BIT = 5,
   parameter int EXP_BIT = 8,
   parameter int N_BIT = 1 << LOG_BIT,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_BIT-1:0] in_data,
   input  logic             in_sub,
   input  logic             in_last,
   input  logic             in_clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N_BIT-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_nan,
   output logic             out_ovf
);
   accum_state_e state;
   logic [N_BIT-1:0] acc, sum;
   logic [CNT_W-1:0] count;
   logic ovf, accept;
   assign in_ready = (state == ACC) && !in_clear && !rst;
   assign accept = in_valid && in_ready;
   fpaddsub #(.LOG_BIT(LOG_BIT), .EXP_BIT(EXP_BIT)) u_add (
      .a(acc), .b(in_data), .addnot_sub(in_sub), .y(sum)
   );
   always_ff @(posedge clk) begin
      if (rst || (state == HOLD && out_ready) || (state == ACC && in_clear)) begin
         acc <= '0;
         count <= '0;
         ovf <= 1'b0;
         state <= ACC;
      end else if (accept) begin
         acc <= sum;
         count <= count + CNT_W'(~&count);
         // overflow only when Inf is newly created, not propagated
         ovf <= ovf | (is_inf(sum) && !is_inf(acc) && !is_inf(in_data));
         if (in_last) state <= HOLD;
      end
   end
   assign out_valid = state == HOLD;
   assign out_data = acc;
   assign out_count = count;
   assign out_nan = is_nan(acc);
   assign out_ovf = ovf;
endmodule

// File: tb/tb_fp_accum_seq.sv
// tb_fp_accum_seq: directed and random sequences checked against a real-arithmetic model
module tb_fp_accum_seq;
   logic clk = 0, rst = 1, in_valid = 0, in_sub = 0, in_last = 0, in_clear = 0, out_ready = 0;
   logic [31:0] in_data = 0;
   logic in_ready, out_valid, out_nan, out_ovf;
   logic [31:0] out_data;
   logic [15:0] out_count;
   int n_chk = 0, n_fail = 0;
   logic [31:0] m_acc = 0;
   int m_cnt = 0;
   logic m_ovf = 0;

   always #5 clk = ~clk;

   fp_accum_seq dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_sub(in_sub), .in_last(in_last), .in_clear(in_clear), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
      .out_nan(out_nan), .out_ovf(out_ovf)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic f_nan(input logic [31:0] x);
      return x[30:23] == 8'hFF && x[22:0] != 0;
   endfunction
   function automatic logic f_inf(input logic [31:0] x);
      return x[30:0] == 31'h7F800000;
   endfunction

   function automatic real f2r(input logic [31:0] a);
      if (a[30:23] == 0) return (a[31] ? -1.0 : 1.0) * real'(a[22:0]) * 2.0 ** (-149);
      return $bitstoreal({a[31], 11'(int'(a[30:23]) + 896), a[22:0], 29'b0});
   endfunction

   // round a double to single precision, nearest-even
   function automatic logic [31:0] r2f(input real x);
      logic [63:0] b;
      logic [52:0] m, q, rem, half;
      int e, sh;
      b = $realtobits(x);
      if (b[62:52] == 0) return {b[63], 31'b0};
      m = {1'b1, b[51:0]};
      e = int'(b[62:52]) - 1023;
      sh = 29 + (e < -126 ? -126 - e : 0);
      if (sh > 53) return {b[63], 31'b0};
      q = m >> sh;
      rem = m & ((53'd1 << sh) - 53'd1);
      half = 53'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 53'd1;
      if (e < -126) return {b[63], q[30:0]};
      if (q[24]) begin
         q = q >> 1;
         e++;
      end
      if (e > 127) return {b[63], 8'hFF, 23'b0};
      return {b[63], 8'(e + 127), q[22:0]};
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic sub);
      logic [31:0] bb;
      bb = b ^ {sub, 31'b0};
      if (f_nan(a) || f_nan(bb)) return 32'h7FC00000;
      if (f_inf(a) && f_inf(bb)) return (a[31] == bb[31]) ? a : 32'h7FC00000;
      if (f_inf(a)) return a;
      if (f_inf(bb)) return bb;
      return r2f(f2r(a) + f2r(bb));
   endfunction

   function automatic logic [31:0] rnd();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
   endfunction

   task automatic model_clear();
      m_acc = 0;
      m_cnt = 0;
      m_ovf = 0;
   endtask

   task automatic send(input logic [31:0] d, input logic s, input logic l);
      logic [31:0] r;
      int w;
      w = 0;
      @(negedge clk);
      in_valid = 1;
      in_data = d;
      in_sub = s;
      in_last = l;
      #1;
      while (!in_ready && w < 20) begin
         @(negedge clk);
         #1;
         w++;
      end
      if (!in_ready) check("ready_timeout", 64'(in_ready), 1);
      check("busy_valid", 64'(out_valid), 0);
      @(posedge clk);
      r = fadd(m_acc, d, s);
      m_ovf = m_ovf | (f_inf(r) && !f_inf(m_acc) && !f_inf(d));
      m_acc = r;
      if (m_cnt < 65535) m_cnt++;
      #1;
      in_valid = 0;
      in_last = 0;
   endtask

   task automatic clear_pulse(input logic v, input logic [31:0] d);
      @(negedge clk);
      in_clear = 1;
      in_valid = v;
      in_data = d;
      in_last = 0;
      #1;
      check("clear_ready", 64'(in_ready), 0);
      @(posedge clk);
      #1;
      in_clear = 0;
      in_valid = 0;
      model_clear();
   endtask

   task automatic take(input int bp, input logic [31:0] exp);
      @(negedge clk);
      check("out_valid", 64'(out_valid), 1);
      check("out_data", 64'(out_data), 64'(exp));
      check("out_count", 64'(out_count), 64'(m_cnt));
      check("out_nan", 64'(out_nan), 64'(f_nan(m_acc)));
      check("out_ovf", 64'(out_ovf), 64'(m_ovf));
      for (int i = 0; i < bp; i++) begin
         in_valid = 1;
         in_data = rnd();
         in_clear = 1'($urandom_range(0, 1));
         #1;
         check("hold_ready", 64'(in_ready), 0);
         @(negedge clk);
         check("hold_data", 64'(out_data), 64'(exp));
         check("hold_valid", 64'(out_valid), 1);
      end
      in_valid = 0;
      in_clear = 0;
      out_ready = 1;
      @(posedge clk);
      #1;
      out_ready = 0;
      model_clear();
      @(negedge clk);
      check("idle_valid", 64'(out_valid), 0);
      check("idle_count", 64'(out_count), 0);
      check("idle_ready", 64'(in_ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_ready", 64'(in_ready), 0);
      check("rst_valid", 64'(out_valid), 0);
      check("rst_data", 64'(out_data), 0);
      check("rst_count", 64'(out_count), 0);
      check("rst_flags", {62'b0, out_nan, out_ovf}, 0);
      rst = 0;
      #1;
      check("post_rst_ready", 64'(in_ready), 1);
      // add chain
      send(32'h3F800000, 0, 0);
      send(32'h40000000, 0, 0);
      send(32'h40400000, 0, 1);
      take(0, 32'h40C00000);
      // cancellation and single-element subtract
      send(32'h40A00000, 0, 0);
      send(32'h40A00000, 1, 1);
      take(0, 32'h00000000);
      send(32'h3F800000, 1, 1);
      take(0, 32'hBF800000);
      // overflow, then Inf - Inf
      send(32'h7F7FFFFF, 0, 0);
      send(32'h7F7FFFFF, 0, 1);
      take(0, 32'h7F800000);
      send(32'h7F800000, 0, 0);
      send(32'hFF800000, 0, 1);
      take(0, 32'h7FC00000);
      // backpressure
      send(32'h3F800000, 0, 0);
      send(32'h40000000, 0, 0);
      send(32'h40400000, 0, 1);
      take(3, 32'h40C00000);
      send(32'h3F800000, 0, 1);
      take(0, 32'h3F800000);
      // clear beats a simultaneous operand
      send(32'h3F800000, 0, 0);
      send(32'h40000000, 0, 0);
      clear_pulse(1, 32'h41000000);
      send(32'h40400000, 0, 1);
      take(0, 32'h40400000);
      // reset mid-sequence
      send(32'h3F800000, 0, 0);
      send(32'h40000000, 0, 0);
      @(negedge clk);
      rst = 1;
      in_valid = 1;
      in_data = 32'h41000000;
      #1;
      check("midrst_ready", 64'(in_ready), 0);
      @(posedge clk);
      #1;
      rst = 0;
      in_valid = 0;
      model_clear();
      @(negedge clk);
      check("midrst_valid", 64'(out_valid), 0);
      check("midrst_count", 64'(out_count), 0);
      send(32'h3F800000, 0, 1);
      take(0, 32'h3F800000);
      // random sequences
      for (int s = 0; s < 40; s++) begin
         int len;
         len = $urandom_range(1, 6);
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 9) == 0) clear_pulse(1'($urandom_range(0, 1)), rnd());
            send(rnd(), 1'($urandom_range(0, 1)), k == len - 1);
         end
         take($urandom_range(0, 3), m_acc);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
